// File: rtl/dmem_store_unit.sv
// Store-side data-memory interface. Accepts one SB/SH/SW store from execute,
// aligns rs2 onto byte lanes with strobes, runs a req/ready/valid handshake
// to data memory while stalling the pipeline, rejects misaligned or illegal
// stores with a fault pulse, and aborts a hung access with a watchdog.
module dmem_store_unit #(
   parameter int unsigned MAX_WAIT   = 16,
   parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic [31:0] dmem_write_address,
   output logic [31:0] dmem_write_data,
   output logic [3:0]  dmem_write_byte,
   output logic        dmem_write_req,
   input  logic        dmem_write_ready,
   input  logic        dmem_write_valid,
   output logic        store_stall,
   output logic        store_fault,
   output logic [31:0] store_exc_addr,
   output logic        timeout
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_WAIT
   } state_t;

   // Last counter value the watchdog tolerates before aborting.
   localparam logic [7:0] LAST_CNT = 8'(MAX_WAIT - 1);

   state_t     state;
   logic [7:0] wait_cnt;

   logic        legal;
   logic [31:0] lane_data;
   logic [3:0]  lane_strb;

   assign req_ready   = (state == S_IDLE);
   assign store_stall = (state != S_IDLE);

   // Decode store width: legality check and lane-aligned data/strobes.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned,
      // which would otherwise infer a latch.
      legal     = 1'b0;
      lane_data = req_wdata;
      lane_strb = 4'b0000;
      case (req_funct3)
         3'b000: begin
            legal     = 1'b1;
            lane_data = {4{req_wdata[7:0]}};
            lane_strb = 4'b0001 << req_addr[1:0];
         end
         3'b001: begin
            legal     = ~req_addr[0];
            lane_data = {2{req_wdata[15:0]}};
            lane_strb = req_addr[1] ? 4'b1100 : 4'b0011;
         end
         3'b010: begin
            legal     = (req_addr[1:0] == 2'b00);
            lane_data = req_wdata;
            lane_strb = 4'b1111;
         end
         default: begin
            legal = 1'b0;
         end
      endcase
   end

   // Transaction FSM with registered memory-side outputs and status pulses.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register in this block sees the pre-edge values of the others.
      if (reset) begin
         state              <= S_IDLE;
         wait_cnt           <= 8'd0;
         dmem_write_address <= 32'd0;
         dmem_write_data    <= 32'd0;
         dmem_write_byte    <= 4'd0;
         dmem_write_req     <= 1'b0;
         store_fault        <= 1'b0;
         timeout            <= 1'b0;
         store_exc_addr     <= RESET_ADDR;
      end else begin
         store_fault <= 1'b0;
         timeout     <= 1'b0;
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  if (legal) begin
                     dmem_write_address <= {req_addr[31:2], 2'b00};
                     dmem_write_data    <= lane_data;
                     dmem_write_byte    <= lane_strb;
                     dmem_write_req     <= 1'b1;
                     wait_cnt           <= 8'd0;
                     state              <= S_REQ;
                  end else begin
                     store_fault    <= 1'b1;
                     store_exc_addr <= req_addr;
                  end
               end
            end
            S_REQ: begin
               if (dmem_write_ready && dmem_write_valid) begin
                  dmem_write_req  <= 1'b0;
                  dmem_write_byte <= 4'd0;
                  state           <= S_IDLE;
               end else if (wait_cnt == LAST_CNT) begin
                  dmem_write_req  <= 1'b0;
                  dmem_write_byte <= 4'd0;
                  timeout         <= 1'b1;
                  store_exc_addr  <= dmem_write_address;
                  state           <= S_IDLE;
               end else if (dmem_write_ready) begin
                  dmem_write_req <= 1'b0;
                  wait_cnt       <= wait_cnt + 8'd1;
                  state          <= S_WAIT;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end
            S_WAIT: begin
               if (dmem_write_valid) begin
                  dmem_write_byte <= 4'd0;
                  state           <= S_IDLE;
               end else if (wait_cnt == LAST_CNT) begin
                  dmem_write_byte <= 4'd0;
                  timeout         <= 1'b1;
                  store_exc_addr  <= dmem_write_address;
                  state           <= S_IDLE;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end
            default: begin
               dmem_write_req  <= 1'b0;
               dmem_write_byte <= 4'd0;
               state           <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/dmem_store_unit.md
Name: dmem_store_unit

Overview:
- Store-side data-memory interface: the write-direction counterpart of the load extraction and writeback logic.
- Accepts one store per transaction from execute (SB/SH/SW). Aligns the rs2 data onto byte lanes and generates byte strobes.
- Drives a request/acknowledge handshake to data memory and stalls the pipeline until the write completes.
- Flags misaligned/illegal stores without touching memory, and includes a watchdog for a hung memory.

Parameters:
- MAX_WAIT, 16: cycles allowed in REQ+WAIT before abort. Legal range 2..255; counter width 8.
- RESET_ADDR, 32'h0000_0000: reset value of store_exc_addr.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  execute presents a store.
- req_ready  out  1  unit can accept a store this cycle.
- req_funct3  in  3  store width: 000 SB, 001 SH, 010 SW; other codes are illegal.
- req_addr  in  32  byte address.
- req_wdata  in  32  rs2 value, right-justified.
- dmem_write_address  out  32  word address {req_addr[31:2],2'b00}.
- dmem_write_data  out  32  lane-aligned store data.
- dmem_write_byte  out  4  byte strobes; bit n enables data[8n+7:8n].
- dmem_write_req  out  1  request to memory.
- dmem_write_ready  in  1  memory accepts the request.
- dmem_write_valid  in  1  memory write completed.
- store_stall  out  1  pipeline must hold.
- store_fault  out  1  1-cycle pulse: misaligned or illegal store rejected.
- store_exc_addr  out  32  address of the last faulting or timed-out store.
- timeout  out  1  1-cycle pulse: watchdog abort.

Behaviour:
- Reset values (synchronous; reset wins over every other event):
  - state=IDLE, wait counter=0.
  - All dmem_* outputs 0; store_fault=0, timeout=0.
  - store_exc_addr=RESET_ADDR.
  - A reset asserted in REQ/WAIT abandons the transaction: dmem_write_req=0 after that edge, and no fault or timeout pulse is issued.
- Control outputs:
  - req_ready=(state==IDLE). store_stall=(state!=IDLE). Both are combinational from state.
- Accept: in IDLE, a cycle with req_valid=1 is a handshake, evaluated at the clock edge.
- Legality:
  - SB is always legal.
  - SH requires addr[0]=0.
  - SW requires addr[1:0]=00.
  - funct3 not in {000,001,010} is illegal.
- Illegal handshake:
  - Stay IDLE, no memory access.
  - store_fault=1 for exactly the next cycle.
  - store_exc_addr<=req_addr.
- Legal handshake: register address, data and strobes; go to REQ. dmem_write_req=1 from the next cycle.
- Lane alignment (registered at accept):
  - SB: data={4{wdata[7:0]}}, strobe=4'b0001<<addr[1:0].
  - SH: data={2{wdata[15:0]}}, strobe=addr[1]?1100:0011.
  - SW: data=wdata, strobe=1111.
- REQ state:
  - dmem_write_req=1; address, data and strobe held stable until dmem_write_ready=1.
  - ready=1 and valid=1 in the same cycle: go to IDLE (single-cycle completion).
  - ready=1 only: go to WAIT; dmem_write_req deasserts on the next cycle.
  - valid=1 without ready: ignored.
- WAIT state:
  - dmem_write_req=0; data and strobe hold their values.
  - dmem_write_valid=1: go to IDLE.
  - dmem_write_ready is ignored.
- Watchdog:
  - Counter clears on accept and increments each cycle in REQ or WAIT.
  - If the counter reaches MAX_WAIT-1 and completion does not occur that cycle: go to IDLE, dmem_write_req=0, timeout pulse for 1 cycle, store_exc_addr<=latched address.
  - Completion in the same cycle as expiry wins; no timeout.
- Strobes: on return to IDLE, dmem_write_byte clears to 0. Data and address may hold.
- Throughput: back-to-back stores are accepted in the IDLE cycle after completion. Minimum 2 cycles per store.
- Stray memory signals: a dmem_write_valid arriving in IDLE is ignored.

Test Plan:
- SW, addr=0x100, wdata=0xDEADBEEF; ready and valid same cycle in REQ → address 0x100, data 0xDEADBEEF, strobe 1111. Req high 1 cycle; stall high 1 cycle; back in IDLE.
- SB at addr 0x103, wdata=0x000000A5 → data 0xA5A5A5A5, strobe 1000. SH at 0x102, wdata=0x1234 → data 0x12341234, strobe 1100. Address 0x100 in both cases.
- Handshake timing: ready at cycle 3 of REQ, valid 4 cycles later → req held 3 cycles, then drops. Stall asserted for exactly REQ+WAIT duration; outputs stable throughout.
- Illegal stores: SH at 0x101 and SW at 0x102 → store_fault pulses once each, store_exc_addr = 0x101 then 0x102, dmem_write_req never asserted. Same for funct3=011.
- Watchdog with MAX_WAIT=16: memory never responds → timeout pulse after 16 cycles in REQ, unit back in IDLE, store_exc_addr = store address. Repeat with valid arriving on the 16th cycle → no timeout.
- Reset mid-operation: reset asserted during WAIT → next cycle IDLE, all outputs 0, no pulses. A following SW completes normally.
